sine_dds_source: RTL and testbench
==================================

# sine_dds_source

Direct-digital-synthesis sine source for the sine-wave bench. A phase accumulator advanced on a programmable sample strobe addresses a quarter-wave lookup table, and a 3-stage pipeline produces 8-bit offset-binary samples. Each sample is presented with a one-cycle valid pulse directly on the 8-bit data input of the downstream DAC model.

## Interface
- `PHASE_W`, 16: phase accumulator and tuning-word width; legal range is 8 or more.
- `DIV`, 4: sample-strobe period in `clk` cycles; legal range is 1 or more.
- `clk`  in  1  clock; all logic runs on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  run enable.
- `phase_clr`  in  1  synchronous phase clear, one-cycle pulse.
- `freq_word`  in  PHASE_W  phase increment; sampled only on strobe cycles.
- `sample_out`  out  8  unsigned offset-binary sample, registered.
- `sample_valid`  out  1  one-cycle pulse; `sample_out` is new in that cycle.
- `phase_wrap`  out  1  one-cycle pulse; the accumulator carried out.

## Operation
- **Prescaler `cnt`** (0..DIV-1):
  - While `en`=1, `cnt` increments and wraps to 0 after DIV-1.
  - While `en`=0, `cnt` is forced to 0.
  - `strobe` = `en` && `cnt`==0. The first enabled cycle is therefore always a strobe. With DIV=1, every enabled cycle is a strobe.
- **Phase accumulator `phase`** (PHASE_W bits, unsigned, modulo 2^PHASE_W):
  - On a strobe: `phase` <= `phase` + `freq_word`. The sum truncates; the carry-out sets `phase_wrap` at the same edge.
  - `phase_clr`=1 forces `phase` <= 0, whether or not this is a strobe. `phase_wrap` is 0 on a clear.
  - With no strobe and no clear, `phase` holds.
- **Sample address:** the sample emitted for a strobe uses the pre-update `phase`.
  - `q` = `phase`[PHASE_W-1:PHASE_W-2]
  - `idx` = `phase`[PHASE_W-3:PHASE_W-8] (6 bits). Lower bits are truncated with no dithering.
- **Quarter-wave ROM:** 64 entries, 7-bit values. Q[k] = floor(127.5·sin(π(2k+1)/256) + 0.5).
  - Q[0]=2, Q[1]=5, Q[63]=127.
- **Quadrant map** (output range is 0..255, with no overflow):
  - q=0: 128+Q[idx]
  - q=1: 128+Q[63−idx]
  - q=2: 127−Q[idx]
  - q=3: 127−Q[63−idx]
- **Pipeline:**
  - S1 registers `q`, `idx` and `v1`=`strobe`.
  - S2 registers the mirrored ROM read (mirroring for q=1 and q=3), the quadrant sign, and `v2`.
  - S3 registers `sample_out` (loaded only when `v2`=1) and `sample_valid`=`v2`.
- **Disable (`en`→0):**
  - No new strobes.
  - Samples already in flight still complete and pulse `sample_valid`.
  - `sample_out` holds its last value indefinitely.
- **Reset values:**
  - `phase`=0, `cnt`=0
  - `v1`=`v2`=0
  - `sample_out`=8'd128 (midscale)
  - `sample_valid`=0, `phase_wrap`=0
- **Reset mid-operation:** all in-flight samples are discarded. `sample_valid` and `phase_wrap` are 0 in the cycle after the reset edge. `rst` has priority over every other input.

## Timing
- Strobe in cycle t → `sample_valid`=1 in cycle t+3, with `sample_out` valid in the same cycle. This fixed latency holds for all DIV.
- Throughput is one sample every DIV cycles. Consecutive `sample_valid` pulses are exactly DIV cycles apart while `en` stays high.
- `phase_wrap` is high in cycle t+1 for a wrapping strobe in cycle t.
- `phase_clr` coincident with a strobe:
  - That strobe still emits the sample for the pre-clear phase.
  - The next strobe emits the sample for phase 0.
- `freq_word` changes take effect at the next strobe. Changes between strobes are ignored.
- After `rst` deasserts with `en`=1: the first strobe is in the first cycle out of reset. The first `sample_valid` is 3 cycles later with value 130.

## Test plan
- **Reset state:** assert `rst` for 3 cycles with `en`=1 → `sample_out`=128, `sample_valid`=0 and `phase_wrap`=0 throughout, and for the first 3 cycles after release.
- **Full period:** DIV=1, PHASE_W=16, `freq_word`=0x0100 → 256 consecutive `sample_valid` pulses.
  - Sample 0=130, 1=133, 63=255, 64=255, 128=125, 192=0.
  - `phase_wrap` pulses once per 256 strobes.
  - The sequence repeats exactly.
- **Quadrant corners:** `freq_word`=0x4000, DIV=4 → samples 130, 255, 125, 0, repeating.
  - `valid` pulses are spaced 4 cycles apart.
  - `phase_wrap` is high 1 cycle after every 4th strobe.
- **Latency and disable:** DIV=1; drop `en` in the cycle after a strobe → exactly 3 further `sample_valid` pulses are counted from the last 3 strobes, then none. `sample_out` then holds.
- **Phase clear:**
  - `freq_word`=0x0100; after 10 samples pulse `phase_clr` coincident with a strobe → that sample=index 10; the next sample=130.
  - Repeat with `phase_clr` between strobes (DIV=4) → the next sample=130.
- **Reset mid-stream:** assert `rst` one cycle after a strobe → no `sample_valid` from the in-flight sample; `sample_out`=128 after the reset edge; the first post-reset sample=130.

Source files
------------

// File: rtl/sine_dds_source.sv
// sine_dds_source
//   Direct-digital-synthesis sine source. A phase accumulator, advanced on a
//   programmable sample strobe, addresses a 64-entry quarter-wave table. A
//   3-stage pipeline turns the phase into 8-bit offset-binary samples, each
//   with a one-cycle valid pulse.
//
// Parameters
//   PHASE_W  accumulator / tuning-word width (>= 8)
//   DIV      sample-strobe period in clk cycles (>= 1)
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active high, overrides every other input
//   en            run enable; low stops new strobes, in-flight samples finish
//   phase_clr     one-cycle pulse, forces the accumulator to zero
//   freq_word     phase increment, sampled only on strobe cycles
//   sample_out    registered offset-binary sample (midscale 128 after reset)
//   sample_valid  one-cycle pulse, sample_out is new in that cycle
//   phase_wrap    one-cycle pulse, the accumulator carried out
module sine_dds_source #(
  parameter int PHASE_W = 16,
  parameter int DIV     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] freq_word,
  output logic [7:0]         sample_out,
  output logic               sample_valid,
  output logic               phase_wrap
);

  localparam int STAGES = 3;
  // Keep the prescaler at least one bit wide so DIV=1 still elaborates;
  // with CNT_MAX=0 it simply stays at zero.
  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0]      cnt;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W:0]   sum;
  logic               strobe;

  // vld_pipe[0]=S1 valid, [1]=S2 valid, [2]=sample_valid
  logic [STAGES-1:0]  vld_pipe;
  logic [1:0]         q1;
  logic [5:0]         idx1;
  logic [6:0]         mag2;
  logic               neg2;
  logic [5:0]         rom_addr;
  logic [6:0]         rom_q;

  assign strobe       = en && (cnt == '0);
  assign sum          = {1'b0, phase} + {1'b0, freq_word};
  // Quadrants 1 and 3 walk the quarter table backwards.
  assign rom_addr     = q1[0] ? ~idx1 : idx1;
  assign sample_valid = vld_pipe[STAGES-1];

  // Q[k] = floor(127.5*sin(pi*(2k+1)/256) + 0.5); half-step offset keeps the
  // four quadrants symmetric about 127.5 with no repeated zero crossing.
  always_comb begin
    rom_q = '0;
    case (rom_addr)
      6'd0:  rom_q = 7'd2;   6'd1:  rom_q = 7'd5;   6'd2:  rom_q = 7'd8;   6'd3:  rom_q = 7'd11;
      6'd4:  rom_q = 7'd14;  6'd5:  rom_q = 7'd17;  6'd6:  rom_q = 7'd20;  6'd7:  rom_q = 7'd23;
      6'd8:  rom_q = 7'd26;  6'd9:  rom_q = 7'd29;  6'd10: rom_q = 7'd32;  6'd11: rom_q = 7'd36;
      6'd12: rom_q = 7'd39;  6'd13: rom_q = 7'd41;  6'd14: rom_q = 7'd44;  6'd15: rom_q = 7'd47;
      6'd16: rom_q = 7'd50;  6'd17: rom_q = 7'd53;  6'd18: rom_q = 7'd56;  6'd19: rom_q = 7'd59;
      6'd20: rom_q = 7'd61;  6'd21: rom_q = 7'd64;  6'd22: rom_q = 7'd67;  6'd23: rom_q = 7'd70;
      6'd24: rom_q = 7'd72;  6'd25: rom_q = 7'd75;  6'd26: rom_q = 7'd77;  6'd27: rom_q = 7'd80;
      6'd28: rom_q = 7'd82;  6'd29: rom_q = 7'd84;  6'd30: rom_q = 7'd87;  6'd31: rom_q = 7'd89;
      6'd32: rom_q = 7'd91;  6'd33: rom_q = 7'd93;  6'd34: rom_q = 7'd96;  6'd35: rom_q = 7'd98;
      6'd36: rom_q = 7'd100; 6'd37: rom_q = 7'd101; 6'd38: rom_q = 7'd103; 6'd39: rom_q = 7'd105;
      6'd40: rom_q = 7'd107; 6'd41: rom_q = 7'd109; 6'd42: rom_q = 7'd110; 6'd43: rom_q = 7'd112;
      6'd44: rom_q = 7'd113; 6'd45: rom_q = 7'd115; 6'd46: rom_q = 7'd116; 6'd47: rom_q = 7'd117;
      6'd48: rom_q = 7'd118; 6'd49: rom_q = 7'd120; 6'd50: rom_q = 7'd121; 6'd51: rom_q = 7'd122;
      6'd52: rom_q = 7'd122; 6'd53: rom_q = 7'd123; 6'd54: rom_q = 7'd124; 6'd55: rom_q = 7'd125;
      6'd56: rom_q = 7'd125; 6'd57: rom_q = 7'd126; 6'd58: rom_q = 7'd126; 6'd59: rom_q = 7'd127;
      6'd60: rom_q = 7'd127; 6'd61: rom_q = 7'd127; 6'd62: rom_q = 7'd127; 6'd63: rom_q = 7'd127;
      default: rom_q = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      phase      <= '0;
      phase_wrap <= 1'b0;
      vld_pipe   <= '0;
      q1         <= '0;
      idx1       <= '0;
      mag2       <= '0;
      neg2       <= 1'b0;
      sample_out <= 8'd128;
    end else begin
      if (!en || cnt == CNT_MAX) cnt <= '0;
      else                       cnt <= cnt + CW'(1);

      // Clear wins over a coincident strobe; S1 below still captures the
      // pre-clear phase, so that strobe's sample is not lost.
      if (phase_clr) begin
        phase      <= '0;
        phase_wrap <= 1'b0;
      end else if (strobe) begin
        phase      <= sum[PHASE_W-1:0];
        phase_wrap <= sum[PHASE_W];
      end else begin
        phase_wrap <= 1'b0;
      end

      vld_pipe <= {vld_pipe[STAGES-2:0], strobe};

      // S1: quadrant and table index from the pre-update phase
      q1   <= phase[PHASE_W-1 -: 2];
      idx1 <= phase[PHASE_W-3 -: 6];

      // S2: mirrored table read and sign (lower half-wave for q=2,3)
      mag2 <= rom_q;
      neg2 <= q1[1];

      // S3: offset-binary output, held between valid samples
      if (vld_pipe[1])
        sample_out <= neg2 ? (8'd127 - {1'b0, mag2}) : (8'd128 + {1'b0, mag2});
    end
  end

endmodule

// File: tb/tb_sine_dds_source.sv
module tb_sine_dds_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        en1, clr1, en4, clr4;
  logic [15:0] fw1, fw4;
  logic [7:0]  s1, s4;
  logic        v1, v4, w1, w4;

  int passed = 0;
  int total  = 0;

  // Quarter-wave table, hand-evaluated from floor(127.5*sin(pi(2k+1)/256)+0.5)
  int qtab [0:63] = '{
      2,   5,   8,  11,  14,  17,  20,  23,  26,  29,  32,  36,  39,  41,  44,  47,
     50,  53,  56,  59,  61,  64,  67,  70,  72,  75,  77,  80,  82,  84,  87,  89,
     91,  93,  96,  98, 100, 101, 103, 105, 107, 109, 110, 112, 113, 115, 116, 117,
    118, 120, 121, 122, 122, 123, 124, 125, 125, 126, 126, 127, 127, 127, 127, 127};

  always #5 clk = ~clk;

  sine_dds_source #(.PHASE_W(16), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .en(en1), .phase_clr(clr1), .freq_word(fw1),
    .sample_out(s1), .sample_valid(v1), .phase_wrap(w1));

  sine_dds_source #(.PHASE_W(16), .DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .en(en4), .phase_clr(clr4), .freq_word(fw4),
    .sample_out(s4), .sample_valid(v4), .phase_wrap(w4));

  function automatic int exp_sample(int ph);
    int q, idx;
    q   = (ph >> 14) & 3;
    idx = (ph >> 8) & 63;
    case (q)
      0:       return 128 + qtab[idx];
      1:       return 128 + qtab[63 - idx];
      2:       return 127 - qtab[idx];
      default: return 127 - qtab[63 - idx];
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  // All checks and input changes happen on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int nwrap, nvld;
    int corner [4] = '{130, 255, 125, 0};
    int lat    [3] = '{119, 122, 125};
    int clrv   [4] = '{125, 122, 130, 133};

    rst = 1'b1; en1 = 1'b1; clr1 = 1'b0; fw1 = 16'h0100;
    en4 = 1'b0; clr4 = 1'b0; fw4 = 16'h4000;

    // reset held 3 cycles with en=1
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out", s1, 128); chk("rst_vld", v1, 0); chk("rst_wrap", w1, 0);
      chk("rst_out4", s4, 128); chk("rst_vld4", v4, 0);
    end
    rst = 1'b0;  // this cycle is the first strobe
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rel_out", s1, 128); chk("rel_vld", v1, 0); chk("rel_wrap", w1, 0);
    end

    // full period, DIV=1, freq_word=0x0100
    nwrap = 0;
    for (int k = 0; k < 509; k++) begin
      tick();
      chk("fp_vld", v1, 1);
      chk("fp_val", s1, exp_sample((k * 256) & 16'hFFFF));
      chk("fp_wrap", w1, int'(k % 256 == 253));
      if (w1) nwrap++;
      if (k == 0)   chk("fp_s0", s1, 130);
      if (k == 1)   chk("fp_s1", s1, 133);
      if (k == 63)  chk("fp_s63", s1, 255);
      if (k == 64)  chk("fp_s64", s1, 255);
      if (k == 128) chk("fp_s128", s1, 125);
      if (k == 192) chk("fp_s192", s1, 0);
      if (k == 320) chk("fp_rep320", s1, 255);
    end

    // drop en the cycle after a strobe: 3 in-flight samples, then hold
    nvld = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 0) en1 = 1'b0;
      if (v1) nvld++;
      if (w1) nwrap++;
      chk("dis_wrap", w1, int'(i == 0));
      if (i < 3) begin
        chk("dis_vld", v1, 1); chk("dis_val", s1, lat[i]);
      end else begin
        chk("dis_idle", v1, 0); chk("dis_hold", s1, 125);
      end
    end
    chk("dis_count", nvld, 3);
    chk("fp_wraps", nwrap, 2);

    // phase clear coincident with a strobe (DIV=1)
    tick(); clr1 = 1'b1;
    tick(); clr1 = 1'b0; en1 = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      tick();
      clr1 = (j == 10);
      if (j < 3) chk("clr_pre", v1, 0);
      else begin
        chk("clr_vld", v1, 1);
        chk("clr_val", s1, (j <= 13) ? exp_sample((j - 3) * 256) : exp_sample((j - 14) * 256));
      end
      if (j == 13) chk("clr_idx10", s1, 160);
      if (j == 14) chk("clr_after", s1, 130);
    end
    en1 = 1'b0;

    // quadrant corners, DIV=4, freq_word=0x4000
    for (int i = 0; i < 4; i++) tick();
    en4 = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      chk("qc_vld", v4, int'(j >= 3 && (j - 3) % 4 == 0));
      if (v4) chk("qc_val", s4, corner[((j - 3) / 4) % 4]);
      chk("qc_wrap", w4, int'(j % 16 == 13));
    end
    en4 = 1'b0;

    // phase clear between strobes, DIV=4 (phase starts at 0x8000)
    for (int i = 0; i < 5; i++) tick();
    fw4 = 16'h0100; en4 = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      tick();
      clr4 = (j == 6);
      chk("clr4_vld", v4, int'(j >= 3 && (j - 3) % 4 == 0));
      if (v4) chk("clr4_val", s4, clrv[(j - 3) / 4]);
      chk("clr4_wrap", w4, 0);
    end
    en4 = 1'b0;

    // reset mid-stream (DIV=1, phase resumes at 0x0500)
    tick(); en1 = 1'b1;
    tick(); tick(); tick();
    chk("mr_vld", v1, 1); chk("mr_val", s1, 145);
    tick();
    chk("mr_val2", s1, 148);
    rst = 1'b1;
    tick();
    chk("mr_rst_vld", v1, 0); chk("mr_rst_out", s1, 128); chk("mr_rst_wrap", w1, 0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mr_flush_vld", v1, 0); chk("mr_flush_out", s1, 128);
    end
    tick();
    chk("mr_first_vld", v1, 1); chk("mr_first_val", s1, 130);
    tick();
    chk("mr_second_val", s1, 133);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
